// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and helpers for the register-bank slaves.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  // Byte-lane merge: lanes with a set strobe take the new data, others keep old.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] data,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = data[8*b +: 8];
      end
    end
    return merged;
  endfunction

  // Word index of a byte address; the byte-offset bits are dropped.
  function automatic int unsigned addr_to_idx(
    input logic [63:0] addr,
    input int unsigned addr_width,
    input int unsigned data_width
  );
    logic [63:0] masked;
    int unsigned lsb;
    lsb    = (data_width == 64) ? 3 : 2;
    masked = addr & ((64'd1 << addr_width) - 64'd1);
    masked = masked >> lsb;
    return masked[31:0];
  endfunction

endpackage

// File: rtl/axi_hold_slot.sv
// One-entry capture register: accepts a beat when empty and holds it until cleared.
module axi_hold_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end

  assign in_ready = !full_reg;
  assign full     = full_reg;
  assign data     = data_reg;

endmodule

// File: rtl/axi_regfile.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, optional read-only
// status words sourced from fabric, SLVERR for out-of-range or read-only writes.
module axi_regfile
  import axi_lite_pkg::*;
#(
  parameter int                             NUM_REGS   = 8,
  parameter int                             DATA_WIDTH = 64,
  parameter int                             ADDR_WIDTH = 12,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_areset,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   val,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   ro_val,
  output logic [NUM_REGS-1:0]              wr_pulse,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int W_WIDTH = DATA_WIDTH + STRB_W;

  logic                              aw_full;
  logic                              w_full;
  logic [ADDR_WIDTH-1:0]             aw_addr;
  logic [W_WIDTH-1:0]                w_bundle;
  logic [DATA_WIDTH-1:0]             w_data;
  logic [STRB_W-1:0]                 w_strb;
  logic                              commit;
  int unsigned                       wr_idx;
  int unsigned                       rd_idx;
  logic [NUM_REGS-1:0]               wr_legal_vec;
  logic [NUM_REGS-1:0]               rd_hit_vec;
  logic [NUM_REGS:0][DATA_WIDTH-1:0] rd_chain;
  logic                              ar_fire;

  logic                              bvalid_reg;
  logic [1:0]                        bresp_reg;
  logic                              rvalid_reg;
  logic [DATA_WIDTH-1:0]             rdata_reg;
  logic [1:0]                        rresp_reg;

  axi_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
    .clk      (s_axi_aclk),
    .srst     (s_axi_areset),
    .in_valid (s_axi_awvalid),
    .in_ready (s_axi_awready),
    .in_data  (s_axi_awaddr),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axi_hold_slot #(.WIDTH(W_WIDTH)) u_w_slot (
    .clk      (s_axi_aclk),
    .srst     (s_axi_areset),
    .in_valid (s_axi_wvalid),
    .in_ready (s_axi_wready),
    .in_data  ({s_axi_wstrb, s_axi_wdata}),
    .clear    (commit),
    .full     (w_full),
    .data     (w_bundle)
  );

  assign {w_strb, w_data} = w_bundle;

  // A pending response blocks the next commit unless it is retired on this edge.
  assign commit = aw_full && w_full && (!bvalid_reg || s_axi_bready);

  assign wr_idx        = addr_to_idx(64'(aw_addr), ADDR_WIDTH, DATA_WIDTH);
  assign rd_idx        = addr_to_idx(64'(s_axi_araddr), ADDR_WIDTH, DATA_WIDTH);
  assign ar_fire       = s_axi_arvalid && !rvalid_reg;
  assign s_axi_arready = !rvalid_reg;
  assign rd_chain[0]   = '0;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
    logic [DATA_WIDTH-1:0] src_word;

    assign rd_hit_vec[gi] = (rd_idx == gi);

    if (RO_MASK[gi]) begin : g_ro
      assign wr_legal_vec[gi]                     = 1'b0;
      assign val[gi*DATA_WIDTH +: DATA_WIDTH]     = INIT_WORD;
      assign wr_pulse[gi]                         = 1'b0;
      assign src_word                             = ro_val[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] word_reg;
      logic                  pulse_reg;
      logic                  hit;
      logic                  unused_ro;

      assign hit = commit && (wr_idx == gi);

      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          word_reg  <= INIT_WORD;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          if (hit) begin
            word_reg <= DATA_WIDTH'(strb_merge(64'(word_reg), 64'(w_data), 8'(w_strb)));
          end
        end
      end

      assign wr_legal_vec[gi]                 = (wr_idx == gi);
      assign val[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
      assign wr_pulse[gi]                     = pulse_reg;
      assign src_word                         = word_reg;
      // Status inputs of writable registers are never returned.
      assign unused_ro                        = ^ro_val[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign rd_chain[gi+1] = rd_chain[gi] | (rd_hit_vec[gi] ? src_word : '0);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= (|wr_legal_vec) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_bready) begin
      bvalid_reg <= 1'b0;
    end
  end

  // Register words are sampled before this edge's commit lands, so a colliding
  // read returns the pre-write value.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_chain[NUM_REGS];
      rresp_reg  <= (|rd_hit_vec) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign s_axi_bvalid = bvalid_reg;
  assign s_axi_bresp  = bresp_reg;
  assign s_axi_rvalid = rvalid_reg;
  assign s_axi_rdata  = rdata_reg;
  assign s_axi_rresp  = rresp_reg;

endmodule

// File: tb/tb_axi_regfile.sv
// Bench for axi_regfile: directed vector table, multi-cycle corner sequences and
// random traffic checked against a byte-level register model.
module tb_axi_regfile;

  localparam int          NR   = 4;
  localparam int          DW   = 64;
  localparam int          AW   = 12;
  localparam logic [255:0] INIT = {64'h0, 64'h0, 64'h1234, 64'h0};
  localparam logic [3:0]  ROM  = 4'b1000;

  logic           clk;
  logic           srst;
  logic [255:0]   val;
  logic [255:0]   ro_val;
  logic [3:0]     wr_pulse;
  logic [AW-1:0]  awaddr;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [7:0]     wstrb;
  logic           wvalid, wready;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic [AW-1:0]  araddr;
  logic           arvalid, arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid, rready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] model [4];

  axi_regfile #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INIT_VAL   (INIT),
    .RO_MASK    (ROM)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (srst),
    .val           (val),
    .ro_val        (ro_val),
    .wr_pulse      (wr_pulse),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) model[i] = INIT[64*i +: 64];
  endfunction

  function automatic logic [255:0] model_val();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Returns expected BRESP and applies a legal write byte by byte.
  function automatic logic [1:0] model_write(input logic [11:0] addr, input logic [63:0] data,
                                             input logic [7:0] strb, output logic [3:0] pulse);
    int idx;
    idx   = int'(addr >> 3);
    pulse = 4'b0000;
    if (idx >= 4) return 2'b10;
    if (ROM[idx[1:0]]) return 2'b10;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) model[idx[1:0]][8*b +: 8] = data[8*b +: 8];
    end
    pulse[idx[1:0]] = 1'b1;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [11:0] addr, output logic [63:0] data,
                                     output logic [1:0] resp);
    int idx;
    idx = int'(addr >> 3);
    if (idx >= 4) begin
      data = 64'h0;
      resp = 2'b10;
    end else begin
      data = ROM[idx[1:0]] ? ro_val[64*idx +: 64] : model[idx[1:0]];
      resp = 2'b00;
    end
  endfunction

  task automatic axi_write(input logic [11:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse_b,
                           output logic [3:0] pulse_after, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 0; w_done = 0;
    resp = 2'b11; pulse_b = 4'hx; pulse_after = 4'hx; lat = -1;
    tick();
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      checks++; failures++;
      $display("FAIL wr_handshake addr=%h actual=stalled required=accepted", addr);
      return;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bvalid) begin
        resp = bresp; pulse_b = wr_pulse; lat = i;
        tick();
        @(negedge clk);
        pulse_after = wr_pulse;
        break;
      end
    end
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [63:0] data,
                          output logic [1:0] resp, output logic rv_on_time);
    bit done, hs;
    done = 0; data = 64'hx; resp = 2'b11; rv_on_time = 1'b0;
    tick();
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      if (hs) begin arvalid = 1'b0; done = 1; break; end
    end
    if (!done) begin
      arvalid = 1'b0;
      checks++; failures++;
      $display("FAIL rd_handshake addr=%h actual=stalled required=accepted", addr);
      return;
    end
    @(negedge clk);
    rv_on_time = rvalid;
    for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
    data = rdata;
    resp = rresp;
    tick();
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic [3:0]  pulse;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [1:0]  r_resp, m_resp;
    logic [63:0] r_data, m_data;
    logic [3:0]  p_b, p_a, m_pulse;
    logic        rv;
    int          lat;

    vecs[0]  = '{1'b0, 12'h008, 64'h0,                   8'h00, 2'b00, 64'h1234,                4'b0000};
    vecs[1]  = '{1'b1, 12'h000, 64'hAABBCCDD_11223344,   8'h0F, 2'b00, 64'h0,                   4'b0001};
    vecs[2]  = '{1'b0, 12'h000, 64'h0,                   8'h00, 2'b00, 64'h00000000_11223344,   4'b0000};
    vecs[3]  = '{1'b1, 12'h018, 64'hFFFFFFFF_FFFFFFFF,   8'hFF, 2'b10, 64'h0,                   4'b0000};
    vecs[4]  = '{1'b1, 12'h020, 64'hFFFFFFFF_FFFFFFFF,   8'hFF, 2'b10, 64'h0,                   4'b0000};
    vecs[5]  = '{1'b0, 12'h018, 64'h0,                   8'h00, 2'b00, 64'hDEAD,                4'b0000};
    vecs[6]  = '{1'b0, 12'h020, 64'h0,                   8'h00, 2'b10, 64'h0,                   4'b0000};
    vecs[7]  = '{1'b1, 12'h00C, 64'h00000000_0000AB00,   8'h02, 2'b00, 64'h0,                   4'b0010};
    vecs[8]  = '{1'b0, 12'h008, 64'h0,                   8'h00, 2'b00, 64'hAB34,                4'b0000};
    vecs[9]  = '{1'b1, 12'h008, 64'hFFFFFFFF_FFFFFFFF,   8'h00, 2'b00, 64'h0,                   4'b0010};
    vecs[10] = '{1'b0, 12'h00F, 64'h0,                   8'h00, 2'b00, 64'hAB34,                4'b0000};
    vecs[11] = '{1'b0, 12'h01C, 64'h0,                   8'h00, 2'b00, 64'hDEAD,                4'b0000};
    vecs[12] = '{1'b0, 12'h027, 64'h0,                   8'h00, 2'b10, 64'h0,                   4'b0000};
    vecs[13] = '{1'b1, 12'h03F, 64'h12345678_9ABCDEF0,   8'hFF, 2'b10, 64'h0,                   4'b0000};

    srst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    ro_val = {64'hDEAD, 64'hFFFF0000_FFFF0000, 64'h5A5A5A5A_5A5A5A5A, 64'hC3C3C3C3_C3C3C3C3};
    model_reset();
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_val", val, INIT);
    chk("rst_val_slice1", val[127:64], 64'h1234);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resps", {bresp, rresp}, 0);
    chk("rst_readies", {awready, wready, arready}, 3'b111);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r_resp, p_b, p_a, lat);
        m_resp = model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, m_pulse);
        $display("vec%0d wr addr=%h data=%h strb=%h bresp=%0d", i, vecs[i].addr, vecs[i].data, vecs[i].strb, r_resp);
        chk($sformatf("vec%0d_bresp", i), r_resp, vecs[i].resp);
        chk($sformatf("vec%0d_pulse", i), p_b, vecs[i].pulse);
        chk($sformatf("vec%0d_pulse_next", i), p_a, 0);
        chk($sformatf("vec%0d_b_latency", i), lat, 2);
        chk($sformatf("vec%0d_val", i), val, model_val());
      end else begin
        axi_read(vecs[i].addr, r_data, r_resp, rv);
        $display("vec%0d rd addr=%h rdata=%h rresp=%0d", i, vecs[i].addr, r_data, r_resp);
        chk($sformatf("vec%0d_rdata", i), r_data, vecs[i].rdata);
        chk($sformatf("vec%0d_rresp", i), r_resp, vecs[i].resp);
        chk($sformatf("vec%0d_r_latency", i), rv, 1);
      end
    end

    // W three cycles ahead of AW, B stalled, second write queued behind it
    tick();
    bready = 1'b0;
    wdata = 64'h01020304_05060708; wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk);
    chk("s3_wready_empty", wready, 1);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk("s3_wready_full", wready, 0);
    chk("s3_awready_empty", awready, 1);
    tick();
    tick();
    awaddr = 12'h010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("s3_no_early_b", bvalid, 0);
    tick();
    void'(model_write(12'h010, 64'h01020304_05060708, 8'hFF, m_pulse));
    @(negedge clk);
    chk("s3_b1_valid", bvalid, 1);
    chk("s3_b1_resp", bresp, 2'b00);
    chk("s3_b1_pulse", wr_pulse, 4'b0100);
    chk("s3_b1_val", val, model_val());
    awaddr = 12'h000; awvalid = 1'b1; wdata = 64'h1; wstrb = 8'hFF; wvalid = 1'b1;
    #1;
    chk("s3_second_ready", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("s3_hold%0d_bvalid", k), bvalid, 1);
      chk($sformatf("s3_hold%0d_readies", k), {awready, wready}, 2'b00);
      chk($sformatf("s3_hold%0d_pulse", k), wr_pulse, 0);
      chk($sformatf("s3_hold%0d_val", k), val, model_val());
      tick();
    end
    bready = 1'b1;
    @(negedge clk);
    chk("s3_b1_still", bvalid, 1);
    tick();
    void'(model_write(12'h000, 64'h1, 8'hFF, m_pulse));
    @(negedge clk);
    chk("s3_b2_valid", bvalid, 1);
    chk("s3_b2_pulse", wr_pulse, 4'b0001);
    chk("s3_b2_val", val, model_val());
    chk("s3_b2_readies", {awready, wready}, 2'b11);
    tick();
    @(negedge clk);
    chk("s3_b_drained", bvalid, 0);
    $display("s3 stalled write pair reg2=%h reg0=%h", val[191:128], val[63:0]);

    // Read and commit of the same register on one edge
    tick();
    awaddr = 12'h000; awvalid = 1'b1; wdata = 64'h5; wstrb = 8'hFF; wvalid = 1'b1;
    @(negedge clk);
    chk("s5_wr_ready", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 12'h000; arvalid = 1'b1;
    @(negedge clk);
    chk("s5_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    void'(model_write(12'h000, 64'h5, 8'hFF, m_pulse));
    @(negedge clk);
    chk("s5_rvalid", rvalid, 1);
    chk("s5_rdata_old", rdata, 64'h1);
    chk("s5_bvalid", bvalid, 1);
    chk("s5_val_new", val, model_val());
    tick();
    axi_read(12'h000, r_data, r_resp, rv);
    $display("s5 rd addr=000 rdata=%h rresp=%0d", r_data, r_resp);
    chk("s5_rdata_new", r_data, 64'h5);

    // Reset with AW captured, W pending and a read response held
    tick();
    araddr = 12'h008; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    tick();
    arvalid = 1'b0;
    awaddr = 12'h000; awvalid = 1'b1;
    @(negedge clk);
    chk("s6_rvalid_pre", rvalid, 1);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("s6_aw_captured", awready, 0);
    wdata = 64'hFFFFFFFF_FFFFFFFF; wstrb = 8'hFF; wvalid = 1'b1; srst = 1'b1;
    tick();
    srst = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("s6_val_init", val, model_val());
    chk("s6_readies", {awready, wready, arready}, 3'b111);
    chk("s6_rdata", rdata, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s6_quiet%0d", k), {bvalid, rvalid, wr_pulse}, 0);
      @(negedge clk);
    end
    $display("s6 reset mid-transaction val=%h", val);

    // Random traffic against the model
    tick();
    for (int i = 0; i < 8; i++) ro_val[32*i +: 32] = $urandom;
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      a = 12'($urandom_range(0, 12'h027));
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, r_resp, p_b, p_a, lat);
        m_resp = model_write(a, d, s, m_pulse);
        $display("rnd%0d wr addr=%h data=%h strb=%h bresp=%0d", n, a, d, s, r_resp);
        chk($sformatf("rnd%0d_bresp", n), r_resp, m_resp);
        chk($sformatf("rnd%0d_pulse", n), p_b, m_pulse);
        chk($sformatf("rnd%0d_val", n), val, model_val());
      end else begin
        axi_read(a, r_data, r_resp, rv);
        model_read(a, m_data, m_resp);
        $display("rnd%0d rd addr=%h rdata=%h rresp=%0d", n, a, r_data, r_resp);
        chk($sformatf("rnd%0d_rdata", n), r_data, m_data);
        chk($sformatf("rnd%0d_rresp", n), r_resp, m_resp);
        chk($sformatf("rnd%0d_r_latency", n), rv, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
